// File: rtl/xsp_stream_driver.sv
// Byte-stream front end for the XSP encrypt/decrypt pair: input FIFO, rolling key,
// registered valid/ready output and a loopback self-check with error counting.
module xsp_stream_driver #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_key_load,
    input  logic [7:0]  cfg_key,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic [7:0]  xsp_data_in,
    output logic [7:0]  xsp_key,
    input  logic [7:0]  xsp_encrypted,
    input  logic [7:0]  xsp_decrypted,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic [15:0] err_count,
    output logic        err_flag
);
    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        NOKEY = 2'd0,
        RUN   = 2'd1,
        REKEY = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      base_key_q, base_key_d;
    logic [7:0]      pending_key_q, pending_key_d;
    logic [7:0]      seq_q, seq_d;
    logic [8:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            m_valid_q, m_valid_d;
    logic            m_last_q, m_last_d;
    logic [7:0]      m_data_q, m_data_d;
    logic [15:0]     err_count_q, err_count_d;
    logic            err_flag_q, err_flag_d;

    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [7:0]      head_data;
    logic            head_last;

    assign fifo_empty  = (count_q == '0);
    assign head_data   = mem_q[rd_ptr_q][8:1];
    assign head_last   = mem_q[rd_ptr_q][0];
    // Readiness uses only registered occupancy, so a full FIFO never pushes through on a pop.
    assign s_ready     = (state_q == RUN) && (count_q != FULL_CNT);
    assign push        = s_valid && s_ready;
    assign pop         = !fifo_empty && (!m_valid_q || m_ready);
    assign xsp_data_in = fifo_empty ? 8'h00 : head_data;
    assign xsp_key     = base_key_q + seq_q;

    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_last      = m_last_q;
    assign err_count   = err_count_q;
    assign err_flag    = err_flag_q;

    // NOTE: the storage array has no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s_data, s_last};
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path infers a latch.
        state_d       = state_q;
        base_key_d    = base_key_q;
        pending_key_d = pending_key_q;
        seq_d         = seq_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        m_last_d      = m_last_q;
        err_count_d   = err_count_q;
        err_flag_d    = err_flag_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            m_data_d  = xsp_encrypted;
            m_last_d  = head_last;
            m_valid_d = 1'b1;
            seq_d     = head_last ? 8'h00 : seq_q + 8'd1;
            if (xsp_decrypted != head_data) begin
                err_flag_d = 1'b1;
                if (err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
            end
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Key transitions override the pop-driven sequence update.
        case (state_q)
            NOKEY: begin
                if (cfg_key_load) begin
                    base_key_d = cfg_key;
                    seq_d      = 8'h00;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (cfg_key_load) begin
                    pending_key_d = cfg_key;
                    state_d       = REKEY;
                end
            end
            REKEY: begin
                if (cfg_key_load) begin
                    pending_key_d = cfg_key;
                end
                if (fifo_empty && !m_valid_q) begin
                    base_key_d = cfg_key_load ? cfg_key : pending_key_q;
                    seq_d      = 8'h00;
                    state_d    = RUN;
                end
            end
            default: state_d = NOKEY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= NOKEY;
            base_key_q    <= 8'h00;
            pending_key_q <= 8'h00;
            seq_q         <= 8'h00;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= 8'h00;
            m_last_q      <= 1'b0;
            err_count_q   <= 16'h0000;
            err_flag_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_key_q    <= base_key_d;
            pending_key_q <= pending_key_d;
            seq_q         <= seq_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_last_q      <= m_last_d;
            err_count_q   <= err_count_d;
            err_flag_q    <= err_flag_d;
        end
    end

endmodule

// File: tb/tb_xsp_stream_driver.sv
// Directed bench for xsp_stream_driver: XOR model of the XSP pair, scoreboard of
// expected output bytes filled at input acceptance and drained at output handshakes.
module tb_xsp_stream_driver;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_key_load;
    logic [7:0]  cfg_key;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [7:0]  xsp_data_in;
    logic [7:0]  xsp_key;
    logic [7:0]  xsp_encrypted;
    logic [7:0]  xsp_decrypted;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_last;
    logic [15:0] err_count;
    logic        err_flag;
    logic [7:0]  corrupt;

    always #5 clk = ~clk;

    assign xsp_encrypted = xsp_data_in ^ xsp_key;
    assign xsp_decrypted = xsp_encrypted ^ xsp_key ^ corrupt;

    xsp_stream_driver #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_key_load  (cfg_key_load),
        .cfg_key       (cfg_key),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .s_last        (s_last),
        .xsp_data_in   (xsp_data_in),
        .xsp_key       (xsp_key),
        .xsp_encrypted (xsp_encrypted),
        .xsp_decrypted (xsp_decrypted),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .err_count     (err_count),
        .err_flag      (err_flag)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t       sb[$];
    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] model_base = 8'h00;
    logic [7:0] model_seq  = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Expected ciphertext is fixed at acceptance: bytes leave in order, so the model key
    // schedule advanced here matches the one applied at capture.
    task automatic expect_byte(input logic [7:0] d, input logic l);
        exp_t e;
        logic [7:0] k;
        k      = model_base + model_seq;
        e.data = d ^ k;
        e.last = l;
        sb.push_back(e);
        model_seq = l ? 8'h00 : model_seq + 8'd1;
    endtask

    // Called just after a falling edge; returns just after the falling edge that follows acceptance.
    task automatic send(input logic [7:0] d, input logic l);
        bit ok;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (s_ready) begin
                ok = 1'b1;
                expect_byte(d, l);
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        check("send_accept", ok, 1'b1);
    endtask

    task automatic load_key(input logic [7:0] k);
        cfg_key      = k;
        cfg_key_load = 1'b1;
        @(negedge clk);
        cfg_key_load = 1'b0;
        model_base   = k;
        model_seq    = 8'h00;
    endtask

    task automatic wait_drained(input string tag);
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check(tag, sb.size(), 0);
    endtask

    // Output monitor: sampled just after the falling edge, once inputs for the coming edge are settled.
    exp_t       mon_e;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    always @(negedge clk) begin
        #1;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && m_valid) begin
                check("hold_m_data", m_data, prev_data);
                check("hold_m_last", m_last, prev_last);
            end
            if (m_valid && m_ready) begin
                check("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check("m_data", m_data, mon_e.data);
                    check("m_last", m_last, mon_e.last);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        cfg_key_load = 1'b0;
        cfg_key      = 8'h00;
        s_valid      = 1'b0;
        s_data       = 8'h00;
        s_last       = 1'b0;
        m_ready      = 1'b0;
        corrupt      = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_m_last", m_last, 1'b0);
        check("rst_xsp_data_in", xsp_data_in, 8'h00);
        check("rst_xsp_key", xsp_key, 8'h00);
        check("rst_err_count", err_count, 16'h0000);
        check("rst_err_flag", err_flag, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("nokey_s_ready", s_ready, 1'b0);

        // Basic frame under key 0x5A
        load_key(8'h5A);
        check("load_s_ready", s_ready, 1'b1);
        check("load_xsp_key", xsp_key, 8'h5A);
        m_ready = 1'b1;
        send(8'h00, 1'b0);
        check("basic_data0", xsp_data_in, 8'h00);
        check("basic_key0", xsp_key, 8'h5A);
        send(8'h01, 1'b0);
        check("basic_data1", xsp_data_in, 8'h01);
        check("basic_key1", xsp_key, 8'h5B);
        send(8'h02, 1'b1);
        check("basic_data2", xsp_data_in, 8'h02);
        check("basic_key2", xsp_key, 8'h5C);
        repeat (3) @(negedge clk);
        check("basic_seq_reset_key", xsp_key, 8'h5A);
        check("basic_err_count", err_count, 16'h0000);
        check("basic_drained", sb.size(), 0);
        check("basic_m_valid_idle", m_valid, 1'b0);

        // Backpressure: one byte held in the output register plus DEPTH in the FIFO
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'h10 + 8'(i), i == 4);
        check("bp_full_s_ready", s_ready, 1'b0);
        check("bp_m_valid", m_valid, 1'b1);
        check("bp_head_m_data", m_data, 8'h10 ^ 8'h5A);
        s_valid = 1'b1;
        s_data  = 8'h15;
        s_last  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_sixth_blocked", s_ready, 1'b0);
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        wait_drained("bp_drain_all");
        @(negedge clk);
        check("bp_s_ready_back", s_ready, 1'b1);

        // Key wrap 0xFE -> 0xFF -> 0x00 (rekey from an idle RUN)
        repeat (2) @(negedge clk);
        load_key(8'hFE);
        check("wrap_rekey_s_ready", s_ready, 1'b0);
        send(8'hA0, 1'b0);
        check("wrap_key0", xsp_key, 8'hFE);
        send(8'hA1, 1'b0);
        check("wrap_key1", xsp_key, 8'hFF);
        send(8'hA2, 1'b1);
        check("wrap_key2", xsp_key, 8'h00);
        repeat (3) @(negedge clk);
        check("wrap_drained", sb.size(), 0);

        // Rekey with three bytes buffered; they keep the old schedule
        m_ready = 1'b0;
        send(8'hB0, 1'b0);
        send(8'hB1, 1'b0);
        send(8'hB2, 1'b0);
        load_key(8'h10);
        for (int i = 0; i < 3; i++) begin
            check("rekey_s_ready_low", s_ready, 1'b0);
            @(negedge clk);
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("rekey_drain_s_ready_low", s_ready, 1'b0);
        wait_drained("rekey_drain_old");
        send(8'hC0, 1'b1);
        check("rekey_new_key", xsp_key, 8'h10);
        check("rekey_new_data", xsp_data_in, 8'hC0);
        repeat (3) @(negedge clk);
        check("rekey_drained", sb.size(), 0);

        // Loopback mismatch on two bytes
        check("mm_err_before", err_count, 16'h0000);
        corrupt = 8'h01;
        send(8'hD0, 1'b0);
        send(8'hD1, 1'b1);
        repeat (3) @(negedge clk);
        corrupt = 8'h00;
        check("mm_err_count", err_count, 16'h0002);
        check("mm_err_flag", err_flag, 1'b1);
        check("mm_drained", sb.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        check("mm_rst_err_count", err_count, 16'h0000);
        check("mm_rst_err_flag", err_flag, 1'b0);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);

        // Reset with a full FIFO and a held output byte
        load_key(8'h33);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'h60 + 8'(i), 1'b0);
        check("mid_full_s_ready", s_ready, 1'b0);
        check("mid_m_valid", m_valid, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_s_ready", s_ready, 1'b0);
        check("mid_rst_m_valid", m_valid, 1'b0);
        check("mid_rst_m_data", m_data, 8'h00);
        check("mid_rst_m_last", m_last, 1'b0);
        check("mid_rst_xsp_data_in", xsp_data_in, 8'h00);
        check("mid_rst_xsp_key", xsp_key, 8'h00);
        check("mid_rst_err_count", err_count, 16'h0000);
        check("mid_rst_err_flag", err_flag, 1'b0);
        rst = 1'b0;
        sb.delete();
        s_valid = 1'b1;
        s_data  = 8'h77;
        s_last  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_nokey_s_ready", s_ready, 1'b0);
            check("mid_nokey_m_valid", m_valid, 1'b0);
            check("mid_nokey_xsp_data_in", xsp_data_in, 8'h00);
        end
        s_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
